// File: rtl/led_tick_gen.sv
// led_tick_gen: advance-pulse rate generator for the LED shifter.
// Ports: clock, i_reset_n (async low), i_enable, i_sel[1:0], i_step -> o_valid.
//   Free-runs at one of four periods when enabled.
//   In step mode it emits one pulse per debounced press of i_step.
module led_tick_gen #(
   parameter int          NB_COUNTER      = 32,
   parameter int unsigned LIMIT_0         = 50000000,
   parameter int unsigned LIMIT_1         = 25000000,
   parameter int unsigned LIMIT_2         = 12500000,
   parameter int unsigned LIMIT_3         = 6250000,
   parameter int          NB_DEBOUNCE     = 20,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clock,
   input  logic       i_reset_n,
   input  logic       i_enable,
   input  logic [1:0] i_sel,
   input  logic       i_step,
   output logic       o_valid
);

   localparam logic [NB_DEBOUNCE-1:0] DB_LAST =
      NB_DEBOUNCE'(DEBOUNCE_CYCLES - 1);

   logic [NB_COUNTER-1:0]  cnt_q, cnt_d;
   logic [NB_COUNTER-1:0]  term;
   logic [1:0]             sel_q;
   logic                   valid_q, valid_d;
   logic                   sync1_q, sync2_q;
   logic [NB_DEBOUNCE-1:0] db_cnt_q, db_cnt_d;
   logic                   db_lvl_q, db_lvl_d;
   logic                   db_prev_q;
   logic                   sel_chg;
   logic                   step_rise;

   always_comb begin
      term = '0;
      unique case (sel_q)
         2'd0: term = NB_COUNTER'(LIMIT_0 - 1);
         2'd1: term = NB_COUNTER'(LIMIT_1 - 1);
         2'd2: term = NB_COUNTER'(LIMIT_2 - 1);
         2'd3: term = NB_COUNTER'(LIMIT_3 - 1);
         default: term = '0;
      endcase
   end

   assign sel_chg = (i_sel != sel_q);

   // The count only advances on consecutive disagreement between the
   // synced button and the accepted level; any agreement restarts it.
   always_comb begin
      db_cnt_d = '0;
      db_lvl_d = db_lvl_q;
      if (sync2_q != db_lvl_q) begin
         if (db_cnt_q == DB_LAST) begin
            db_lvl_d = ~db_lvl_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   // Rise is taken from the registered level, which adds the extra
   // clock between level acceptance and the step pulse.
   assign step_rise = db_lvl_q & ~db_prev_q;

   // A period change wins over everything, including a coinciding
   // terminal count or a pending step pulse.
   always_comb begin
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      if (sel_chg) begin
         cnt_d = '0;
      end else if (i_enable) begin
         if (cnt_q == term) begin
            cnt_d   = '0;
            valid_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         valid_d = step_rise;
      end
   end

   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q     <= '0;
         sel_q     <= '0;
         valid_q   <= 1'b0;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_cnt_q  <= '0;
         db_lvl_q  <= 1'b0;
         db_prev_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         sel_q     <= i_sel;
         valid_q   <= valid_d;
         sync1_q   <= i_step;
         sync2_q   <= sync1_q;
         db_cnt_q  <= db_cnt_d;
         db_lvl_q  <= db_lvl_d;
         db_prev_q <= db_lvl_q;
      end
   end

   assign o_valid = valid_q;

endmodule

// File: tb/tb_led_tick_gen.sv
// tb_led_tick_gen: directed scenarios plus randomized traffic for led_tick_gen,
// checked against a behavioural model and hand-computed pulse positions.
module tb_led_tick_gen;

   localparam int DEB = 3;

   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic       en    = 1'b0;
   logic [1:0] sel   = 2'd0;
   logic       step  = 1'b0;
   logic       o_valid;

   int errors = 0;
   int checks = 0;

   led_tick_gen #(
      .NB_COUNTER     (8),
      .LIMIT_0        (4),
      .LIMIT_1        (8),
      .LIMIT_2        (1),
      .LIMIT_3        (16),
      .NB_DEBOUNCE    (4),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clock    (clock),
      .i_reset_n(rst_n),
      .i_enable (en),
      .i_sel    (sel),
      .i_step   (step),
      .o_valid  (o_valid)
   );

   always #5 clock = ~clock;

   // Behavioural model: period phase by edge counting, debounced level
   // from a sliding window over the raw button samples.
   int lim [4] = '{4, 8, 1, 16};
   int m_phase;
   int m_sel;
   bit m_lvl;
   bit m_rose;
   bit smp [$];
   bit exp_v = 1'b0;

   always @(posedge clock) begin
      bit tog;
      bit pstep;
      int n;
      if (!rst_n) begin
         m_phase = 0;
         m_sel   = 0;
         m_lvl   = 1'b0;
         m_rose  = 1'b0;
         smp.delete();
         repeat (DEB + 2) smp.push_back(1'b0);
         exp_v = 1'b0;
      end else begin
         // level flips when the DEB samples seen through the 2-FF
         // synchronizer all disagree with it
         n   = smp.size();
         tog = 1'b1;
         for (int j = 0; j < DEB; j++)
            if (smp[n-2-j] == m_lvl) tog = 1'b0;
         pstep = m_rose && !en;
         if (int'(sel) != m_sel) begin
            m_phase = 0;
            exp_v   = 1'b0;
         end else if (en) begin
            m_phase++;
            if (m_phase == lim[m_sel]) begin
               m_phase = 0;
               exp_v   = 1'b1;
            end else begin
               exp_v = 1'b0;
            end
         end else begin
            exp_v = pstep;
         end
         m_sel  = int'(sel);
         m_rose = tog && !m_lvl;
         if (tog) m_lvl = !m_lvl;
         smp.push_back(step);
         void'(smp.pop_front());
      end
      #1;
      checks++;
      if (o_valid !== exp_v) begin
         errors++;
         $display("FAIL model t=%0t o_valid=%b expected=%b",
                  $time, o_valid, exp_v);
      end
   end

   task automatic chk(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, req);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, act, req);
      end
   endtask

   int pulses;
   int hold;

   initial begin
      // reset
      repeat (3) @(negedge clock);
      chk("reset_low", o_valid, 1'b0);
      en    = 1'b1;
      sel   = 2'd0;
      rst_n = 1'b1;

      // free run, period 4
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         chk("run4", o_valid, (k % 4) == 0);
      end
      for (int k = 13; k <= 15; k++) begin
         @(negedge clock);
         chk("run4b", o_valid, 1'b0);
      end

      // sel change coinciding with terminal count
      sel = 2'd1;
      for (int k = 16; k <= 32; k++) begin
         @(negedge clock);
         chk("selchg8", o_valid, k > 16 && ((k - 16) % 8) == 0);
      end

      // period 1 holds high, disable drops it
      sel = 2'd2;
      for (int k = 33; k <= 38; k++) begin
         @(negedge clock);
         chk("lim1", o_valid, k >= 34);
      end
      en = 1'b0;
      @(negedge clock);
      chk("lim1_off", o_valid, 1'b0);

      // step presses
      pulses = 0;
      for (int p = 0; p < 2; p++) begin
         step = 1'b1;
         for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            chk("press", o_valid, k == 6);
            pulses += int'(o_valid);
         end
         step = 1'b0;
         for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            chk("release", o_valid, 1'b0);
            pulses += int'(o_valid);
         end
      end
      chk_int("press_count", pulses, 2);

      // bounces shorter than the debounce window
      pulses = 0;
      for (int r = 0; r < 5; r++) begin
         step = 1'b1;
         repeat (2) begin
            @(negedge clock);
            pulses += int'(o_valid);
         end
         step = 1'b0;
         repeat (2) begin
            @(negedge clock);
            pulses += int'(o_valid);
         end
      end
      repeat (8) begin
         @(negedge clock);
         pulses += int'(o_valid);
      end
      chk_int("glitch_count", pulses, 0);

      // hold across disable, resume
      sel = 2'd3;
      en  = 1'b1;
      @(negedge clock);
      chk("s3_clear", o_valid, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         chk("s3_run", o_valid, 1'b0);
      end
      en = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         chk("s3_hold", o_valid, 1'b0);
      end
      en = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         chk("s3_resume", o_valid, k == 6);
      end

      // async reset mid-operation
      rst_n = 1'b0;
      #1;
      chk("async_rst", o_valid, 1'b0);
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clock);
         chk("post_rst", o_valid, k == 17);
      end

      // randomized traffic, checked by the model every cycle
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         if (!rst_n) begin
            rst_n = 1'b1;
         end else if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
         end
         if ($urandom_range(0, 39) == 0) en = ~en;
         if ($urandom_range(0, 59) == 0) sel = 2'($urandom_range(0, 3));
         if (hold == 0) begin
            step = ~step;
            hold = $urandom_range(1, 8);
         end else begin
            hold--;
         end
      end

      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
